// File: rtl/mem_port_arb.sv
// Single-port RAM arbiter between instruction fetch and data load/store.
// Data wins by default; fetch is forced through after STARVE_MAX back-to-back data grants.
module mem_port_arb #(
  parameter int ADDRW      = 32,
  parameter int DATAW      = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [ADDRW-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_stall,
  output logic             if_rvalid,
  output logic [DATAW-1:0] if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [ADDRW-1:0] d_addr,
  input  logic [DATAW-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [DATAW-1:0] d_rdata,
  output logic [ADDRW-1:0] mem_ad,
  output logic [DATAW-1:0] mem_d,
  output logic             mem_we,
  input  logic [DATAW-1:0] mem_q
);

  logic [3:0]        starve_cnt;
  logic              fetch_forced;
  logic              d_win;
  logic              tag_load_vld;
  logic              tag_load_is_d;
  logic [RD_LAT-1:0] tag_vld;
  logic [RD_LAT-1:0] tag_is_d;
  logic              resp_vld;
  logic [DATAW-1:0]  if_rdata_hold;
  logic [DATAW-1:0]  d_rdata_hold;

  assign fetch_forced = if_req && (starve_cnt == 4'(STARVE_MAX));
  assign d_win        = d_req && !fetch_forced;

  // Grants are suppressed during reset so nothing reaches the RAM or the pc hold.
  assign d_gnt    = !reset && d_win;
  assign if_gnt   = !reset && if_req && !d_win;
  assign if_stall = !reset && if_req && !if_gnt;

  assign mem_ad = d_gnt ? d_addr : if_addr;
  assign mem_d  = d_wdata;
  assign mem_we = d_gnt && d_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (if_gnt || !if_req) begin
      starve_cnt <= '0;
    end else if (d_gnt && (starve_cnt < 4'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign tag_load_vld  = if_gnt || (d_gnt && !d_we);
  assign tag_load_is_d = d_gnt;

  // Shift-left form keeps the same code valid for a one-deep pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld  <= '0;
      tag_is_d <= '0;
    end else begin
      tag_vld  <= (tag_vld << 1) | RD_LAT'(tag_load_vld);
      tag_is_d <= (tag_is_d << 1) | RD_LAT'(tag_load_is_d);
    end
  end

  assign resp_vld  = !reset && tag_vld[RD_LAT-1];
  assign if_rvalid = resp_vld && !tag_is_d[RD_LAT-1];
  assign d_rvalid  = resp_vld && tag_is_d[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      if_rdata_hold <= '0;
      d_rdata_hold  <= '0;
    end else begin
      if (if_rvalid) if_rdata_hold <= mem_q;
      if (d_rvalid)  d_rdata_hold  <= mem_q;
    end
  end

  // Read data passes straight through in its valid cycle, otherwise the last value is held.
  assign if_rdata = reset ? '0 : (if_rvalid ? mem_q : if_rdata_hold);
  assign d_rdata  = reset ? '0 : (d_rvalid  ? mem_q : d_rdata_hold);

endmodule
